// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared constants and helpers for the nibble-stream blocks.
//   NIBBLE_W   : width of one stream lane (4 bits)
//   idx_width  : index counter width for a given number of nibbles per word
//   keep_mask  : lane index -> thermometer mask (bits 0..idx set)
// -----------------------------------------------------------------------------
package axis_pkg;

   localparam int NIBBLE_W = 4;

   function automatic int idx_width(input int nibbles);
      return (nibbles <= 2) ? 1 : $clog2(nibbles);
   endfunction

   function automatic logic [15:0] keep_mask(input logic [3:0] idx);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         m[i] = (i <= int'(idx));
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_nibble_packer.sv
// -----------------------------------------------------------------------------
// axis_nibble_packer
// Packs a 4-bit valid/ready stream into words of NIBBLES nibbles, little-endian
// (first nibble in tdata_o[3:0]). One nibble per cycle sustained, no bubbles at
// word boundaries.
//
// Optional feature: macro PACKER_TLAST_EN adds tlast_i, tkeep_o and tlast_o;
// tlast_i closes a short word early.
//
// Ports
//   clk_i     in   clock, rising edge
//   arstn_i   in   asynchronous active-low reset
//   tvalid_i  in   upstream nibble valid
//   tready_o  out  packer can accept a nibble (combinational from tready_i)
//   tdata_i   in   upstream nibble
//   tlast_i   in   last nibble of packet            (PACKER_TLAST_EN only)
//   tvalid_o  out  packed word valid, registered
//   tready_i  in   downstream ready
//   tdata_o   out  packed word, registered
//   tkeep_o   out  per-nibble lane valid mask       (PACKER_TLAST_EN only)
//   tlast_o   out  packet end                       (PACKER_TLAST_EN only)
// -----------------------------------------------------------------------------
module axis_nibble_packer
   import axis_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                          clk_i,
   input  logic                          arstn_i,
   input  logic                          tvalid_i,
   output logic                          tready_o,
   input  logic [NIBBLE_W-1:0]           tdata_i,
`ifdef PACKER_TLAST_EN
   input  logic                          tlast_i,
`endif
   output logic                          tvalid_o,
   input  logic                          tready_i,
`ifdef PACKER_TLAST_EN
   output logic [NIBBLE_W*NIBBLES-1:0]   tdata_o,
   output logic [NIBBLES-1:0]            tkeep_o,
   output logic                          tlast_o
`else
   output logic [NIBBLE_W*NIBBLES-1:0]   tdata_o
`endif
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int AW = NIBBLE_W * (NIBBLES - 1);
   localparam int IW = idx_width(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   logic [IW-1:0] idx_q,   idx_d;
   logic [AW-1:0] acc_q,   acc_d;
   logic [W-1:0]  data_q,  data_d;
   logic          valid_q, valid_d;

   logic          last_lane;
   logic          complete_req;
   logic          hs_in;
   logic          hs_out;
   logic [W-1:0]  nib_shift;

`ifdef PACKER_TLAST_EN
   logic [NIBBLES-1:0] keep_q, keep_d;
   logic               last_q, last_d;
   logic [15:0]        keep_full;
`endif

   always_comb begin
      last_lane = (idx_q == LAST_IDX);
`ifdef PACKER_TLAST_EN
      // Any nibble may complete a word, so every nibble waits for a free output.
      tready_o     = ~valid_q | tready_i;
      complete_req = last_lane | tlast_i;
`else
      // Only the completing nibble needs the output register.
      tready_o     = ~last_lane | ~valid_q | tready_i;
      complete_req = last_lane;
`endif
      hs_in  = tvalid_i & tready_o;
      hs_out = valid_q & tready_i;
   end

   // Accumulator lanes at and above idx are always zero, so OR-ing the
   // shifted nibble both fills its lane and forms the completed word.
   assign nib_shift = W'(tdata_i) << {idx_q, 2'b00};

`ifdef PACKER_TLAST_EN
   assign keep_full = keep_mask(4'(idx_q));
`endif

   always_comb begin
      idx_d   = idx_q;
      acc_d   = acc_q;
      data_d  = data_q;
      valid_d = valid_q;
`ifdef PACKER_TLAST_EN
      keep_d  = keep_q;
      last_d  = last_q;
`endif
      if (hs_out) begin
         valid_d = 1'b0;
      end
      if (hs_in) begin
         if (complete_req) begin
            data_d  = W'(acc_q) | nib_shift;
            valid_d = 1'b1;
            idx_d   = '0;
            acc_d   = '0;
`ifdef PACKER_TLAST_EN
            keep_d  = keep_full[NIBBLES-1:0];
            last_d  = tlast_i;
`endif
         end else begin
            acc_d = acc_q | nib_shift[AW-1:0];
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         idx_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef PACKER_TLAST_EN
         keep_q  <= '0;
         last_q  <= 1'b0;
`endif
      end else begin
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef PACKER_TLAST_EN
         keep_q  <= keep_d;
         last_q  <= last_d;
`endif
      end
   end

   assign tvalid_o = valid_q;
   assign tdata_o  = data_q;
`ifdef PACKER_TLAST_EN
   assign tkeep_o  = keep_q;
   assign tlast_o  = last_q;
`endif

endmodule

// File: tb/tb_axis_nibble_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_nibble_packer
// Directed vectors plus a randomized gap run for axis_nibble_packer (NIBBLES=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A negedge monitor keeps a scoreboard of completed words.
// -----------------------------------------------------------------------------
module tb_axis_nibble_packer;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        tvalid_i;
   logic        tready_o;
   logic [3:0]  tdata_i;
   logic        tvalid_o;
   logic        tready_i;
   logic [15:0] tdata_o;
`ifdef PACKER_TLAST_EN
   logic        tlast_i;
   logic [3:0]  tkeep_o;
   logic        tlast_o;
`endif

   axis_nibble_packer #(.NIBBLES(4)) dut (
      .clk_i    (clk_i),
      .arstn_i  (arstn_i),
      .tvalid_i (tvalid_i),
      .tready_o (tready_o),
      .tdata_i  (tdata_i),
`ifdef PACKER_TLAST_EN
      .tlast_i  (tlast_i),
      .tkeep_o  (tkeep_o),
      .tlast_o  (tlast_o),
`endif
      .tvalid_o (tvalid_o),
      .tready_i (tready_i),
      .tdata_o  (tdata_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   int stalls   = 0;
   int words_out = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one nibble; returns one time unit after the edge that accepted it.
   task automatic put(input logic [3:0] d);
      int t;
      tvalid_i = 1'b1;
      tdata_i  = d;
      t = 0;
      @(negedge clk_i);
      while (!tready_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      stalls += t;
      check("put_ready", {31'd0, tready_o}, 32'd1);
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard: reference packing of accepted nibbles, compared at hs_out.
   logic [15:0] exp_q[$];
   logic [15:0] m_acc;
   int          m_idx;
   logic        prev_stall;
   logic [15:0] prev_data;
   logic [15:0] exp_w;
   logic        m_done;

   always @(negedge clk_i) begin
      if (!arstn_i) begin
         m_acc = '0;
         m_idx = 0;
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", {31'd0, tvalid_o}, 32'd1);
            check("stall_data", {16'd0, tdata_o}, {16'd0, prev_data});
         end
         if (tvalid_o && tready_i) begin
            words_out++;
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            check("sb_word", {16'd0, tdata_o}, (exp_q.size() >= 0 && exp_w !== 16'hxxxx)
                  ? {16'd0, exp_w} : 32'hDEAD_BEEF);
         end
         if (tvalid_i && tready_o) begin
            m_acc = m_acc | (16'(tdata_i) << (4 * m_idx));
            m_done = (m_idx == 3);
`ifdef PACKER_TLAST_EN
            m_done = m_done | tlast_i;
`endif
            if (m_done) begin
               exp_q.push_back(m_acc);
               m_acc = '0;
               m_idx = 0;
            end else begin
               m_idx++;
            end
         end
         prev_stall = tvalid_o && !tready_i;
         prev_data  = tdata_o;
      end
   end

   int sent;
   int cyc;
   int words_before;
   logic [3:0] nib;
   logic acc_ok;

   initial begin
      arstn_i  = 1'b0;
      tvalid_i = 1'b0;
      tdata_i  = 4'h0;
      tready_i = 1'b1;
`ifdef PACKER_TLAST_EN
      tlast_i  = 1'b0;
`endif
      #3;
      check("rst_tvalid", {31'd0, tvalid_o}, 32'd0);
      check("rst_tdata", {16'd0, tdata_o}, 32'd0);
      check("rst_tready", {31'd0, tready_o}, 32'd1);
`ifdef PACKER_TLAST_EN
      check("rst_tkeep", {28'd0, tkeep_o}, 32'd0);
      check("rst_tlast", {31'd0, tlast_o}, 32'd0);
`endif
      @(posedge clk_i); #1;
      arstn_i = 1'b1;

      // T1: single word, valid for exactly one cycle
      put(4'h1); put(4'h2); put(4'h3); put(4'h4);
      tvalid_i = 1'b0;
      @(negedge clk_i);
      check("t1_valid", {31'd0, tvalid_o}, 32'd1);
      check("t1_data", {16'd0, tdata_o}, 32'h4321);
      @(negedge clk_i);
      check("t1_one_cycle", {31'd0, tvalid_o}, 32'd0);
      @(posedge clk_i); #1;

      // T2: 8 nibbles continuous, no stall
      stalls = 0;
      for (int i = 0; i < 8; i++) put(4'(i));
      tvalid_i = 1'b0;
      check("t2_no_stall", stalls, 0);
      @(negedge clk_i);
      check("t2_valid", {31'd0, tvalid_o}, 32'd1);
      check("t2_data", {16'd0, tdata_o}, 32'h7654);

`ifndef PACKER_TLAST_EN
      // T3: output stalled, accumulation continues until the completing nibble
      @(posedge clk_i); #1;
      put(4'h1); put(4'h2); put(4'h3); put(4'h4);
      tready_i = 1'b0;
      stalls = 0;
      put(4'h5); put(4'h6); put(4'h7);
      check("t3_accum_no_stall", stalls, 0);
      tvalid_i = 1'b1;
      tdata_i  = 4'h8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("t3_tready_low", {31'd0, tready_o}, 32'd0);
         check("t3_hold_data", {16'd0, tdata_o}, 32'h4321);
         check("t3_hold_valid", {31'd0, tvalid_o}, 32'd1);
      end
      @(posedge clk_i); #1;
      tready_i = 1'b1;
      @(negedge clk_i);
      check("t3_tready_comb", {31'd0, tready_o}, 32'd1);
      @(posedge clk_i); #1;
      tvalid_i = 1'b0;
      @(negedge clk_i);
      check("t3_valid", {31'd0, tvalid_o}, 32'd1);
      check("t3_data", {16'd0, tdata_o}, 32'h8765);
`endif

      // T4: reset mid-word
      @(posedge clk_i); #1;
      put(4'hA); put(4'hB);
      tvalid_i = 1'b0;
      @(posedge clk_i); #1;
      arstn_i = 1'b0;
      #1;
      check("t4_rst_valid", {31'd0, tvalid_o}, 32'd0);
      check("t4_rst_data", {16'd0, tdata_o}, 32'd0);
      check("t4_rst_ready", {31'd0, tready_o}, 32'd1);
      @(negedge clk_i);
      @(posedge clk_i); #1;
      arstn_i = 1'b1;
      put(4'h1); put(4'h2); put(4'h3); put(4'h4);
      tvalid_i = 1'b0;
      @(negedge clk_i);
      check("t4_valid", {31'd0, tvalid_o}, 32'd1);
      check("t4_data", {16'd0, tdata_o}, 32'h4321);

`ifdef PACKER_TLAST_EN
      // T5: short word closed by tlast, then a full word
      @(posedge clk_i); #1;
      put(4'h9);
      tlast_i = 1'b1;
      put(4'hC);
      tlast_i = 1'b0;
      tvalid_i = 1'b0;
      @(negedge clk_i);
      check("t5_data", {16'd0, tdata_o}, 32'h00C9);
      check("t5_keep", {28'd0, tkeep_o}, 32'h3);
      check("t5_last", {31'd0, tlast_o}, 32'd1);
      @(posedge clk_i); #1;
      put(4'h1); put(4'h2); put(4'h3); put(4'h4);
      tvalid_i = 1'b0;
      @(negedge clk_i);
      check("t5_full_keep", {28'd0, tkeep_o}, 32'hF);
      check("t5_full_last", {31'd0, tlast_o}, 32'd0);
`endif

      // T6: random valid/ready gaps over 1000 nibbles
      @(posedge clk_i); #1;
      words_before = words_out;
      sent = 0;
      cyc  = 0;
      nib  = 4'h0;
      tvalid_i = 1'b0;
      while (sent < 1000 && cyc < 20000) begin
         @(negedge clk_i);
         acc_ok = tvalid_i && tready_o;
         @(posedge clk_i); #1;
         if (acc_ok) begin
            sent++;
            nib = nib + 4'h1;
         end
         if (!tvalid_i || acc_ok) begin
            tvalid_i = ($urandom_range(0, 2) != 0) && (sent < 1000);
            tdata_i  = nib;
         end
         tready_i = ($urandom_range(0, 2) != 0);
         cyc++;
      end
      tvalid_i = 1'b0;
      tready_i = 1'b1;
      repeat (10) @(posedge clk_i);
      @(negedge clk_i);
      check("rand_sent", sent, 1000);
      check("rand_words", words_out - words_before, 250);
      check("rand_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
